regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Shares the register file's single write port between the main pipeline writeback and a long-latency unit (mul/div, load miss). It also keeps a per-register busy scoreboard, so decode stalls on operands that an outstanding long-latency op will write. It sits between writeback/long-latency unit and the register file's `rd_en`/`rd_addr`/`rd_data` inputs. A starvation counter guarantees forward progress for the long-latency unit.

## Interface
- `ADDR_SIZE`, 5: register address width; 2**ADDR_SIZE registers.
- `WORD_SIZE`, 32: data width.
- `STARVE_LIMIT`, 8: cycles a valid long-latency result may wait before the block forces a drain.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pipe_en` in 1: pipeline writeback valid; has priority and cannot be back-pressured.
- `pipe_addr` in ADDR_SIZE: pipeline destination register.
- `pipe_data` in WORD_SIZE: pipeline result.
- `lu_valid` in 1: long-latency result valid.
- `lu_ready` out 1: long-latency result accepted this cycle when high with `lu_valid`.
- `lu_addr` in ADDR_SIZE: long-latency destination register.
- `lu_data` in WORD_SIZE: long-latency result.
- `issue_en` in 1: a long-latency op issues this cycle.
- `issue_addr` in ADDR_SIZE: register the issuing op reserves.
- `rs_addr`, `rt_addr` in ADDR_SIZE: decode source operands.
- `dst_en` in 1: decode instruction writes a register.
- `dst_addr` in ADDR_SIZE: decode destination.
- `stall` out 1: freeze decode/issue.
- `rd_en` out 1: register-file write enable.
- `rd_addr` out ADDR_SIZE: register-file write address.
- `rd_data` out WORD_SIZE: register-file write data.

## Operation
- Write mux is combinational, with zero latency to the register file:
  - `pipe_en`=1: `rd_*` = pipe fields, `lu_ready`=0.
  - Else `lu_ready`=1; if `lu_valid`, `rd_*` = lu fields.
  - Otherwise `rd_en`=0.
- `lu_ready` depends only on `pipe_en` and state, never on `lu_valid`.
- Writes to address 0 are suppressed: `rd_en`=0. A long-latency handshake to address 0 still completes.
- Scoreboard: busy[2**ADDR_SIZE], register 0 never busy.
  - Set on `issue_en` (`issue_addr`≠0).
  - Cleared on the edge where `lu_valid&&lu_ready` for `lu_addr`.
  - Same-edge set and clear of the same address: set wins.
- Hazard: `haz` = busy[rs_addr] | busy[rt_addr] | (`dst_en` & busy[dst_addr]). Combinational from registered busy bits.
- FSM states:
  - RUN: `wait_cnt` counts cycles with `lu_valid&&!lu_ready`; it clears on handshake or when `lu_valid`=0. At `wait_cnt`==STARVE_LIMIT-1 with another refused cycle, go to DRAIN.
  - DRAIN: `stall`=1 forced; wait for handshake, then go to RUN with `wait_cnt`=0.
- `stall` = `haz` | (state==DRAIN).
- Upstream contract: `pipe_en` falls within pipeline depth of `stall`; `issue_en` is never asserted while `stall`=1.

## Timing
- Reset (async assert): busy all 0, state RUN, `wait_cnt`=0.
  - Outputs while `rst`=1: `rd_en`=0, `lu_ready`=0, `stall`=0, `rd_addr`=0, `rd_data`=0.
- Write latency 0: the register file captures on the same edge as the handshake.
- Busy clears on that same edge. Decode reading the register next cycle gets the new value and sees `stall`=0.
- `issue_en` at edge N makes `stall` visible for dependents from cycle N+1.
- Starvation bound: result waits at most STARVE_LIMIT + pipeline drain cycles.
- Reset mid-DRAIN or with busy bits set discards all state; in-flight lu results after reset are accepted normally but clear nothing.

## Test plan
- Reset with `lu_valid`=1, `pipe_en`=1: all outputs 0. After release, `rd_en`=1 with pipe fields, `lu_ready`=0.
- `issue_en` addr 5; next cycle `rs_addr`=5: `stall`=1. Handshake lu addr 5 data 0xDEADBEEF with `pipe_en`=0: `rd_en`=1, `rd_addr`=5; next cycle `stall`=0.
- `pipe_en` and `lu_valid` same cycle: pipe written, `lu_ready`=0. Next cycle `pipe_en`=0: lu written, `lu_ready`=1.
- `pipe_en` held 1 and `lu_valid` held for 8 cycles (STARVE_LIMIT=8): `stall` rises on cycle 9. Drop `pipe_en`: handshake, then `stall` falls if no hazard.
- Writes to addr 0 from either source: `rd_en`=0. Lu handshake completes; `issue_en` addr 0 never stalls.
- `issue_en` addr 7 on the same edge as lu handshake addr 7: busy[7] remains 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register-file write port between the
// pipeline writeback and a long-latency unit. It also tracks busy registers.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   pipe_en/addr/data         pipeline writeback (priority, never held off)
//   lu_valid/ready/addr/data  long-latency result handshake
//   issue_en/issue_addr       long-latency issue, reserves a register
//   rs_addr, rt_addr          decode source operands
//   dst_en, dst_addr          decode destination
//   stall                     freeze decode/issue
//   rd_en/rd_addr/rd_data     register-file write port
module regfile_wb_arbiter #(
   parameter int ADDR_SIZE    = 5,
   parameter int WORD_SIZE    = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pipe_en,
   input  logic [ADDR_SIZE-1:0] pipe_addr,
   input  logic [WORD_SIZE-1:0] pipe_data,
   input  logic                 lu_valid,
   output logic                 lu_ready,
   input  logic [ADDR_SIZE-1:0] lu_addr,
   input  logic [WORD_SIZE-1:0] lu_data,
   input  logic                 issue_en,
   input  logic [ADDR_SIZE-1:0] issue_addr,
   input  logic [ADDR_SIZE-1:0] rs_addr,
   input  logic [ADDR_SIZE-1:0] rt_addr,
   input  logic                 dst_en,
   input  logic [ADDR_SIZE-1:0] dst_addr,
   output logic                 stall,
   output logic                 rd_en,
   output logic [ADDR_SIZE-1:0] rd_addr,
   output logic [WORD_SIZE-1:0] rd_data
);

   localparam int NREG = 2 ** ADDR_SIZE;
   localparam int CW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(STARVE_LIMIT - 1);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t          state;
   logic [CW-1:0]   wait_cnt;
   logic [NREG-1:0] busy;
   logic            hs;
   logic            haz;

   // Write mux. Outputs are forced quiet while reset is held.
   always_comb begin
      rd_en    = 1'b0;
      rd_addr  = '0;
      rd_data  = '0;
      lu_ready = 1'b0;
      if (!rst) begin
         lu_ready = !pipe_en;
         if (pipe_en) begin
            rd_en   = (pipe_addr != '0);
            rd_addr = pipe_addr;
            rd_data = pipe_data;
         end else if (lu_valid) begin
            rd_en   = (lu_addr != '0);
            rd_addr = lu_addr;
            rd_data = lu_data;
         end
      end
   end

   assign hs = lu_valid & lu_ready;

   assign haz = busy[rs_addr] | busy[rt_addr] | (dst_en & busy[dst_addr]);

   assign stall = !rst & (haz | (state == DRAIN));

   // Scoreboard: the set is applied last so it wins over a same-edge clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (hs) begin
            busy[lu_addr] <= 1'b0;
         end
         if (issue_en && issue_addr != '0) begin
            busy[issue_addr] <= 1'b1;
         end
      end
   end

   // Starvation guard: after STARVE_LIMIT refused cycles, force a stall
   // so the pipeline drains and the long-latency result gets the port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (hs || !lu_valid) begin
                  wait_cnt <= '0;
               end else if (wait_cnt == LAST) begin
                  state    <= DRAIN;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DRAIN: begin
               wait_cnt <= '0;
               if (hs) begin
                  state <= RUN;
               end
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule
